// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC generator.
//   - ctrl_type_e   : per-slot control-transfer type reported by the BTB
//   - fetch_state_e : fetch FSM states
//   - isTaken()     : per-slot predicted-taken decision
package fetch_pkg;

    // Encoding matches the 2-bit per-slot ctrlType field delivered by the BTB.
    typedef enum logic [1:0] {
        RETURN = 2'b00,
        CALL   = 2'b01,
        JUMP   = 2'b10,
        COND   = 2'b11
    } ctrl_type_e;

    typedef enum logic {
        RUN       = 1'b0,
        MISS_WAIT = 1'b1
    } fetch_state_e;

    // Unconditional transfers are always taken on a BTB hit; conditionals
    // follow the direction predictor.
    function automatic logic isTaken(input logic hit, input logic pred,
                                     input logic [1:0] ctype);
        return hit & (pred | (ctype != COND));
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with checkpoint restore.
// Ports:
//   clk, reset (async, active-low)
//   push_i / pushAddr_i : write pushAddr_i at (base+1) and move tos there
//   pop_i               : move tos down by one
//   restore_i / restoreTos_i : base pointer is restoreTos_i instead of tos
//   clear_i             : tos and count back to 0 (entries untouched)
//   tos_o / top_o / empty_o : pointer, entry at pointer, count==0
module ras_stack
    import fetch_pkg::*;
#(
    parameter int SIZE_PC   = 32,
    parameter int RAS_DEPTH = 16,
    localparam int PTR_W    = $clog2(RAS_DEPTH),
    localparam int CNT_W    = $clog2(RAS_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [SIZE_PC-1:0] pushAddr_i,
    input  logic               pop_i,
    input  logic               restore_i,
    input  logic [PTR_W-1:0]   restoreTos_i,
    input  logic               clear_i,
    output logic [PTR_W-1:0]   tos_o,
    output logic [SIZE_PC-1:0] top_o,
    output logic               empty_o
);

    logic [SIZE_PC-1:0] entries_q [RAS_DEPTH];
    logic [PTR_W-1:0]   tos_q;
    logic [PTR_W-1:0]   tos_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   base;
    logic [PTR_W-1:0]   writeIdx;
    logic               writeEn;

    // Pointer and occupancy update. A restore may be combined with a push
    // (decode-found call on the same redirect), so the push is applied on
    // top of the restored pointer. The pointer wraps freely; only the count
    // saturates, so overflow silently overwrites the oldest entry and an
    // underflowing pop still moves the pointer.
    always_comb begin
        base     = restore_i ? restoreTos_i : tos_q;
        writeIdx = base + PTR_W'(1);
        tos_d    = base;
        count_d  = count_q;
        writeEn  = 1'b0;
        if (clear_i) begin
            tos_d   = '0;
            count_d = '0;
        end else if (push_i) begin
            tos_d   = writeIdx;
            writeEn = 1'b1;
            if (count_q != CNT_W'(RAS_DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i) begin
            tos_d = base - PTR_W'(1);
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Stack storage and pointers; reset clears every entry so the top of an
    // empty stack reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            tos_q   <= '0;
            count_q <= '0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            if (writeEn) begin
                entries_q[writeIdx] <= pushAddr_i;
            end
        end
    end

    assign tos_o   = tos_q;
    assign top_o   = entries_q[tos_q];
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: selects the next fetch PC from recovery, exception,
// execute/decode redirects, BTB predictions and the sequential path, runs
// the I-cache miss FSM and drives the return-address stack.
// Ports:
//   clk, reset (async, active-low), stall_i
//   recoverFlag_i/recoverPC_i, exceptionFlag_i/exceptionPC_i
//   flagRecoverEX_i/targetAddrEX_i, flagRecoverID_i/targetAddrID_i
//   flagCallID_i/callPCID_i, rasTosRestore_i
//   btbHit_i, prediction_i, ctrlType_i, targetAddr_i (per slot)
//   icacheMiss_i, refillDone_i
//   pc_o, fetchValid_o, takenSlot_o, takenValid_o, rasTos_o, rasTop_o, rasEmpty_o
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                FETCH_WIDTH = 4,
    parameter int                SIZE_PC     = 32,
    parameter int                INST_BYTES  = 8,
    parameter int                RAS_DEPTH   = 16,
    parameter logic [SIZE_PC-1:0] RESET_PC   = '0,
    localparam int SLOT_W    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall_i,
    input  logic                           recoverFlag_i,
    input  logic [SIZE_PC-1:0]             recoverPC_i,
    input  logic                           exceptionFlag_i,
    input  logic [SIZE_PC-1:0]             exceptionPC_i,
    input  logic                           flagRecoverEX_i,
    input  logic [SIZE_PC-1:0]             targetAddrEX_i,
    input  logic                           flagRecoverID_i,
    input  logic [SIZE_PC-1:0]             targetAddrID_i,
    input  logic                           flagCallID_i,
    input  logic [SIZE_PC-1:0]             callPCID_i,
    input  logic [RAS_PTR_W-1:0]           rasTosRestore_i,
    input  logic [FETCH_WIDTH-1:0]         btbHit_i,
    input  logic [FETCH_WIDTH-1:0]         prediction_i,
    input  logic [2*FETCH_WIDTH-1:0]       ctrlType_i,
    input  logic [SIZE_PC*FETCH_WIDTH-1:0] targetAddr_i,
    input  logic                           icacheMiss_i,
    input  logic                           refillDone_i,
    output logic [SIZE_PC-1:0]             pc_o,
    output logic                           fetchValid_o,
    output logic [SLOT_W-1:0]              takenSlot_o,
    output logic                           takenValid_o,
    output logic [RAS_PTR_W-1:0]           rasTos_o,
    output logic [SIZE_PC-1:0]             rasTop_o,
    output logic                           rasEmpty_o
);

    localparam logic [SIZE_PC-1:0] PC_STEP = SIZE_PC'(FETCH_WIDTH * INST_BYTES);

    fetch_state_e       state_q;
    logic [SIZE_PC-1:0] pc_q;
    logic [SIZE_PC-1:0] pc_d;

    logic               takenValid;
    logic [SLOT_W-1:0]  takenSlot;
    ctrl_type_e         takenType;
    logic [SIZE_PC-1:0] takenTarget;
    logic [SIZE_PC-1:0] takenRetAddr;

    logic               redirect;
    logic               advance;
    logic               rasPush;
    logic               rasPop;
    logic               rasRestore;
    logic               rasClear;
    logic [SIZE_PC-1:0] rasPushAddr;

    // Lowest predicted-taken slot. Scanning from the top slot down lets the
    // lowest hit overwrite any higher one. The return address of a call is
    // the slot after it in the bundle.
    always_comb begin
        takenValid   = 1'b0;
        takenSlot    = '0;
        takenType    = JUMP;
        takenTarget  = '0;
        takenRetAddr = '0;
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            if (isTaken(btbHit_i[k], prediction_i[k], ctrlType_i[2*k +: 2])) begin
                takenValid   = 1'b1;
                takenSlot    = SLOT_W'(k);
                takenType    = ctrl_type_e'(ctrlType_i[2*k +: 2]);
                takenTarget  = targetAddr_i[SIZE_PC*k +: SIZE_PC];
                takenRetAddr = pc_q + SIZE_PC'((k + 1) * INST_BYTES);
            end
        end
    end

    assign redirect = recoverFlag_i | exceptionFlag_i | flagRecoverEX_i | flagRecoverID_i;
    assign advance  = (state_q == RUN) & ~stall_i & ~icacheMiss_i;

    // Next-PC selection and RAS control. Redirects bypass stall and the miss
    // FSM; speculative push/pop only happens when the PC actually advances,
    // so a stalled call never touches the stack.
    always_comb begin
        pc_d        = pc_q;
        rasPush     = 1'b0;
        rasPop      = 1'b0;
        rasRestore  = 1'b0;
        rasClear    = 1'b0;
        rasPushAddr = takenRetAddr;
        if (recoverFlag_i) begin
            pc_d     = recoverPC_i;
            rasClear = 1'b1;
        end else if (exceptionFlag_i) begin
            pc_d     = exceptionPC_i;
            rasClear = 1'b1;
        end else if (flagRecoverEX_i) begin
            pc_d       = targetAddrEX_i;
            rasRestore = 1'b1;
        end else if (flagRecoverID_i) begin
            pc_d       = targetAddrID_i;
            rasRestore = 1'b1;
            if (flagCallID_i) begin
                rasPush     = 1'b1;
                rasPushAddr = callPCID_i;
            end
        end else if (advance) begin
            if (takenValid) begin
                case (takenType)
                    RETURN: begin
                        pc_d   = rasTop_o;
                        rasPop = 1'b1;
                    end
                    CALL: begin
                        pc_d    = takenTarget;
                        rasPush = 1'b1;
                    end
                    default: pc_d = takenTarget;
                endcase
            end else begin
                pc_d = pc_q + PC_STEP;
            end
        end
    end

    // PC register and miss FSM. Leaving MISS_WAIT on refill keeps the PC so
    // the same bundle is fetched again; any redirect returns straight to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            if (redirect) begin
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN:       if (icacheMiss_i) state_q <= MISS_WAIT;
                    MISS_WAIT: if (refillDone_i) state_q <= RUN;
                    default:   state_q <= RUN;
                endcase
            end
        end
    end

    ras_stack #(
        .SIZE_PC   (SIZE_PC),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .reset        (reset),
        .push_i       (rasPush),
        .pushAddr_i   (rasPushAddr),
        .pop_i        (rasPop),
        .restore_i    (rasRestore),
        .restoreTos_i (rasTosRestore_i),
        .clear_i      (rasClear),
        .tos_o        (rasTos_o),
        .top_o        (rasTop_o),
        .empty_o      (rasEmpty_o)
    );

    assign pc_o         = pc_q;
    assign fetchValid_o = (state_q == RUN) & ~icacheMiss_i;
    assign takenSlot_o  = takenSlot;
    assign takenValid_o = takenValid;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed vector table, hand-written multi-cycle
// sequences (reset abandoning a miss, RAS overflow/underflow) and a random
// run checked against a behavioural model of the fetch rules.
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    localparam int FW  = 4;
    localparam int PCW = 32;
    localparam int IB  = 8;
    localparam int RD  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall_i;
    logic             recoverFlag_i;
    logic [PCW-1:0]   recoverPC_i;
    logic             exceptionFlag_i;
    logic [PCW-1:0]   exceptionPC_i;
    logic             flagRecoverEX_i;
    logic [PCW-1:0]   targetAddrEX_i;
    logic             flagRecoverID_i;
    logic [PCW-1:0]   targetAddrID_i;
    logic             flagCallID_i;
    logic [PCW-1:0]   callPCID_i;
    logic [3:0]       rasTosRestore_i;
    logic [FW-1:0]    btbHit_i;
    logic [FW-1:0]    prediction_i;
    logic [2*FW-1:0]  ctrlType_i;
    logic [PCW*FW-1:0] targetAddr_i;
    logic             icacheMiss_i;
    logic             refillDone_i;
    logic [PCW-1:0]   pc_o;
    logic             fetchValid_o;
    logic [1:0]       takenSlot_o;
    logic             takenValid_o;
    logic [3:0]       rasTos_o;
    logic [PCW-1:0]   rasTop_o;
    logic             rasEmpty_o;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .FETCH_WIDTH (FW),
        .SIZE_PC     (PCW),
        .INST_BYTES  (IB),
        .RAS_DEPTH   (RD),
        .RESET_PC    (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .recoverFlag_i   (recoverFlag_i),
        .recoverPC_i     (recoverPC_i),
        .exceptionFlag_i (exceptionFlag_i),
        .exceptionPC_i   (exceptionPC_i),
        .flagRecoverEX_i (flagRecoverEX_i),
        .targetAddrEX_i  (targetAddrEX_i),
        .flagRecoverID_i (flagRecoverID_i),
        .targetAddrID_i  (targetAddrID_i),
        .flagCallID_i    (flagCallID_i),
        .callPCID_i      (callPCID_i),
        .rasTosRestore_i (rasTosRestore_i),
        .btbHit_i        (btbHit_i),
        .prediction_i    (prediction_i),
        .ctrlType_i      (ctrlType_i),
        .targetAddr_i    (targetAddr_i),
        .icacheMiss_i    (icacheMiss_i),
        .refillDone_i    (refillDone_i),
        .pc_o            (pc_o),
        .fetchValid_o    (fetchValid_o),
        .takenSlot_o     (takenSlot_o),
        .takenValid_o    (takenValid_o),
        .rasTos_o        (rasTos_o),
        .rasTop_o        (rasTop_o),
        .rasEmpty_o      (rasEmpty_o)
    );

    typedef struct packed {
        logic             stall;
        logic             rec;
        logic [31:0]      recPc;
        logic             exc;
        logic [31:0]      excPc;
        logic             ex;
        logic [31:0]      exTgt;
        logic             id;
        logic [31:0]      idTgt;
        logic             idCall;
        logic [31:0]      callPc;
        logic [3:0]       restore;
        logic [3:0]       hit;
        logic [3:0]       pred;
        logic [3:0][1:0]  ctype;
        logic [3:0][31:0] tgt;
        logic             miss;
        logic             refill;
        logic [31:0]      ePc;
        logic [3:0]       eTos;
        logic [31:0]      eTop;
        logic             eEmpty;
        logic             eFv;
        logic             eTv;
        logic [1:0]       eTs;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [31:0] mPc;
    bit          mMiss;
    int          mTos;
    int          mCnt;
    logic [31:0] mRas [RD];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stall_i         = v.stall;
        recoverFlag_i   = v.rec;
        recoverPC_i     = v.recPc;
        exceptionFlag_i = v.exc;
        exceptionPC_i   = v.excPc;
        flagRecoverEX_i = v.ex;
        targetAddrEX_i  = v.exTgt;
        flagRecoverID_i = v.id;
        targetAddrID_i  = v.idTgt;
        flagCallID_i    = v.idCall;
        callPCID_i      = v.callPc;
        rasTosRestore_i = v.restore;
        btbHit_i        = v.hit;
        prediction_i    = v.pred;
        ctrlType_i      = v.ctype;
        targetAddr_i    = v.tgt;
        icacheMiss_i    = v.miss;
        refillDone_i    = v.refill;
    endtask

    function automatic vec_t idle(input logic [31:0] pc, input logic [3:0] tos,
                                  input logic [31:0] top, input logic empty);
        vec_t v;
        v        = '0;
        v.ePc    = pc;
        v.eTos   = tos;
        v.eTop   = top;
        v.eEmpty = empty;
        v.eFv    = 1'b1;
        return v;
    endfunction

    task automatic checkRow(input int idx, input vec_t v);
        string p;
        p = $sformatf("row%0d", idx);
        checkOutput({p, ".pc"}, pc_o, v.ePc);
        checkOutput({p, ".tos"}, 32'(rasTos_o), 32'(v.eTos));
        checkOutput({p, ".top"}, rasTop_o, v.eTop);
        checkOutput({p, ".empty"}, 32'(rasEmpty_o), 32'(v.eEmpty));
        checkOutput({p, ".fetchValid"}, 32'(fetchValid_o), 32'(v.eFv));
        checkOutput({p, ".takenValid"}, 32'(takenValid_o), 32'(v.eTv));
        if (v.eTv) checkOutput({p, ".takenSlot"}, 32'(takenSlot_o), 32'(v.eTs));
    endtask

    // Lowest slot whose BTB entry is a taken transfer, -1 if none.
    function automatic int firstTaken();
        for (int k = 0; k < FW; k++) begin
            if (btbHit_i[k] && (prediction_i[k] || ctrlType_i[2*k +: 2] != 2'b11)) return k;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mPc   = 32'h0;
        mMiss = 1'b0;
        mTos  = 0;
        mCnt  = 0;
        for (int i = 0; i < RD; i++) mRas[i] = 32'h0;
    endtask

    task automatic modelCheck(input int cyc);
        int k;
        k = firstTaken();
        checkOutput($sformatf("rnd%0d.pc", cyc), pc_o, mPc);
        checkOutput($sformatf("rnd%0d.tos", cyc), 32'(rasTos_o), 32'(mTos));
        checkOutput($sformatf("rnd%0d.top", cyc), rasTop_o, mRas[mTos]);
        checkOutput($sformatf("rnd%0d.empty", cyc), 32'(rasEmpty_o), 32'(mCnt == 0));
        checkOutput($sformatf("rnd%0d.fetchValid", cyc), 32'(fetchValid_o), 32'(!mMiss && !icacheMiss_i));
        checkOutput($sformatf("rnd%0d.takenValid", cyc), 32'(takenValid_o), 32'(k >= 0));
        if (k >= 0) checkOutput($sformatf("rnd%0d.takenSlot", cyc), 32'(takenSlot_o), 32'(k));
    endtask

    task automatic modelStep();
        int k;
        bit redir;
        k     = firstTaken();
        redir = recoverFlag_i || exceptionFlag_i || flagRecoverEX_i || flagRecoverID_i;
        if (recoverFlag_i) begin
            mPc = recoverPC_i; mTos = 0; mCnt = 0;
        end else if (exceptionFlag_i) begin
            mPc = exceptionPC_i; mTos = 0; mCnt = 0;
        end else if (flagRecoverEX_i) begin
            mPc = targetAddrEX_i; mTos = int'(rasTosRestore_i);
        end else if (flagRecoverID_i) begin
            mPc  = targetAddrID_i;
            mTos = int'(rasTosRestore_i);
            if (flagCallID_i) begin
                mTos       = (mTos + 1) % RD;
                mRas[mTos] = callPCID_i;
                mCnt       = (mCnt < RD) ? mCnt + 1 : RD;
            end
        end else if (!mMiss && !stall_i && !icacheMiss_i) begin
            if (k < 0) begin
                mPc = mPc + 32'(FW * IB);
            end else if (ctrlType_i[2*k +: 2] == 2'b00) begin
                mPc  = mRas[mTos];
                mTos = (mTos + RD - 1) % RD;
                mCnt = (mCnt > 0) ? mCnt - 1 : 0;
            end else begin
                if (ctrlType_i[2*k +: 2] == 2'b01) begin
                    mTos       = (mTos + 1) % RD;
                    mRas[mTos] = mPc + 32'((k + 1) * IB);
                    mCnt       = (mCnt < RD) ? mCnt + 1 : RD;
                end
                mPc = targetAddr_i[32*k +: 32];
            end
        end
        if (redir) mMiss = 1'b0;
        else if (!mMiss && icacheMiss_i) mMiss = 1'b1;
        else if (mMiss && refillDone_i) mMiss = 1'b0;
    endtask

    task automatic randomInputs();
        vec_t v;
        v        = '0;
        v.rec    = ($urandom_range(0, 63) == 0);
        v.recPc  = $urandom;
        v.exc    = ($urandom_range(0, 63) == 0);
        v.excPc  = $urandom;
        v.ex     = ($urandom_range(0, 19) == 0);
        v.exTgt  = $urandom;
        v.id     = ($urandom_range(0, 19) == 0);
        v.idTgt  = $urandom;
        v.idCall = $urandom_range(0, 1) == 1;
        v.callPc = $urandom;
        v.restore = 4'($urandom_range(0, 15));
        v.stall  = ($urandom_range(0, 4) == 0);
        v.hit    = 4'($urandom) & 4'($urandom);
        v.pred   = 4'($urandom);
        v.ctype  = 8'($urandom);
        for (int k = 0; k < FW; k++) v.tgt[k] = $urandom;
        v.miss   = ($urandom_range(0, 7) == 0);
        v.refill = ($urandom_range(0, 2) == 0);
        applyStimulus(v);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] q [$];
        logic [31:0] curPc;
        logic [31:0] exp;

        // Directed table, one row per cycle; expectations are the values seen
        // before the edge that consumes that row's inputs.
        for (int i = 0; i < 4; i++) tbl[i] = idle(32'(i * 32), 0, 0, 1);
        tbl[4] = idle(32'h80, 0, 0, 1);  tbl[4].rec = 1; tbl[4].recPc = 32'h100;
        tbl[5] = idle(32'h100, 0, 0, 1); tbl[5].hit = 4'b0100; tbl[5].ctype[2] = 2'b01;
        tbl[5].tgt[2] = 32'h400; tbl[5].eTv = 1; tbl[5].eTs = 2;
        tbl[6] = idle(32'h400, 1, 32'h118, 0); tbl[6].hit = 4'b0001; tbl[6].ctype[0] = 2'b00;
        tbl[6].eTv = 1; tbl[6].eTs = 0;
        tbl[7] = idle(32'h118, 0, 0, 1);
        tbl[8] = idle(32'h138, 0, 0, 1); tbl[8].rec = 1; tbl[8].recPc = 32'h800;
        tbl[8].ex = 1; tbl[8].exTgt = 32'h900; tbl[8].restore = 5;
        tbl[9] = idle(32'h800, 0, 0, 1); tbl[9].exc = 1; tbl[9].excPc = 32'h200;
        tbl[10] = idle(32'h200, 0, 0, 1); tbl[10].miss = 1; tbl[10].eFv = 0;
        tbl[11] = idle(32'h200, 0, 0, 1); tbl[11].miss = 1; tbl[11].eFv = 0;
        tbl[12] = idle(32'h200, 0, 0, 1); tbl[12].refill = 1; tbl[12].eFv = 0;
        tbl[13] = idle(32'h200, 0, 0, 1);
        tbl[14] = idle(32'h220, 0, 0, 1); tbl[14].miss = 1; tbl[14].eFv = 0;
        tbl[15] = idle(32'h220, 0, 0, 1); tbl[15].id = 1; tbl[15].idTgt = 32'h300; tbl[15].eFv = 0;
        tbl[16] = idle(32'h300, 0, 0, 1);
        tbl[17] = idle(32'h320, 0, 0, 1); tbl[17].stall = 1; tbl[17].hit = 4'b0010;
        tbl[17].ctype[1] = 2'b01; tbl[17].tgt[1] = 32'h700; tbl[17].eTv = 1; tbl[17].eTs = 1;
        tbl[18] = tbl[17];
        tbl[19] = tbl[17]; tbl[19].ex = 1; tbl[19].exTgt = 32'h500; tbl[19].restore = 3;
        tbl[20] = idle(32'h500, 3, 0, 1);
        tbl[21] = idle(32'h520, 3, 0, 1); tbl[21].hit = 4'b1010;
        tbl[21].ctype[3] = 2'b11; tbl[21].ctype[1] = 2'b11; tbl[21].pred = 4'b0010;
        tbl[21].tgt[1] = 32'h640; tbl[21].eTv = 1; tbl[21].eTs = 1;
        tbl[22] = idle(32'h640, 3, 0, 1); tbl[22].id = 1; tbl[22].idTgt = 32'h1000;
        tbl[22].idCall = 1; tbl[22].callPc = 32'h1234; tbl[22].restore = 7;
        tbl[22].hit = 4'b0001; tbl[22].ctype[0] = 2'b10; tbl[22].tgt[0] = 32'h9999;
        tbl[22].eTv = 1; tbl[22].eTs = 0;
        tbl[23] = idle(32'h1000, 8, 32'h1234, 0); tbl[23].hit = 4'b0001;
        tbl[23].ctype[0] = 2'b00; tbl[23].eTv = 1; tbl[23].eTs = 0;
        tbl[24] = idle(32'h1234, 7, 0, 1); tbl[24].hit = 4'b1000;
        tbl[24].ctype[3] = 2'b00; tbl[24].eTv = 1; tbl[24].eTs = 3;
        tbl[25] = idle(32'h0, 6, 0, 1);

        // Reset values, with fetchValid following icacheMiss while held
        v = '0;
        applyStimulus(v);
        icacheMiss_i = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.pc", pc_o, 32'h0);
        checkOutput("reset.empty", 32'(rasEmpty_o), 32'h1);
        checkOutput("reset.top", rasTop_o, 32'h0);
        checkOutput("reset.tos", 32'(rasTos_o), 32'h0);
        checkOutput("reset.fetchValidMiss", 32'(fetchValid_o), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(tbl[i]);
            #1;
            checkRow(i, tbl[i]);
            @(negedge clk);
        end

        // Reset in the middle of MISS_WAIT abandons the miss
        v = '0;
        applyStimulus(v);
        icacheMiss_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("missReset.inMiss", 32'(fetchValid_o), 32'h0);
        icacheMiss_i = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("missReset.pc", pc_o, 32'h0);
        checkOutput("missReset.fetchValid", 32'(fetchValid_o), 32'h1);
        checkOutput("missReset.empty", 32'(rasEmpty_o), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("missReset.firstEdge", pc_o, 32'h20);

        // 17 calls overflow the 16-entry stack; 16 returns give the newest
        // addresses back in reverse order.
        curPc = 32'h20;
        for (int i = 0; i < 17; i++) begin
            v = '0;
            v.hit = 4'b0001;
            v.ctype[0] = 2'b01;
            v.tgt[0] = 32'h1000 + 32'(i * 64);
            applyStimulus(v);
            q.push_back(curPc + 32'(IB));
            if (q.size() > RD) void'(q.pop_front());
            curPc = v.tgt[0];
            @(negedge clk);
        end
        #1;
        checkOutput("ovf.tos", 32'(rasTos_o), 32'h1);
        checkOutput("ovf.empty", 32'(rasEmpty_o), 32'h0);
        for (int i = 0; i < RD; i++) begin
            v = '0;
            v.hit = 4'b0001;
            v.ctype[0] = 2'b00;
            applyStimulus(v);
            exp = q.pop_back();
            checkOutput($sformatf("ovf.top%0d", i), rasTop_o, exp);
            @(negedge clk);
            #1;
            checkOutput($sformatf("ovf.pc%0d", i), pc_o, exp);
        end
        v = '0;
        applyStimulus(v);
        checkOutput("ovf.drained", 32'(rasEmpty_o), 32'h1);

        // Random run against the behavioural model
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int c = 0; c < 1500; c++) begin
            randomInputs();
            #1;
            modelCheck(c);
            modelStep();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
Parameters (name, default, meaning):
REQ-001 FETCH_WIDTH, 4, instruction slots fetched per cycle (1..8).
REQ-002 SIZE_PC, 32, PC width in bits.
REQ-003 INST_BYTES, 8, byte stride between consecutive slots.
REQ-004 RAS_DEPTH, 16, return-address-stack entries (power of 2, >=2).
REQ-005 RESET_PC, 0, PC value loaded on reset.

Ports (name, direction, width, meaning):
REQ-006 One clock, clk, input, 1, all state on its rising edge.
REQ-007 reset, input, 1, asynchronous, active-low.
REQ-008 stall_i, input, 1, back-pressure from the downstream stage.
REQ-009 recoverFlag_i / recoverPC_i, input, 1 / SIZE_PC, commit-time recovery.
REQ-010 exceptionFlag_i / exceptionPC_i, input, 1 / SIZE_PC, exception redirect.
REQ-011 flagRecoverEX_i / targetAddrEX_i, input, 1 / SIZE_PC, execute-stage redirect.
REQ-012 flagRecoverID_i / targetAddrID_i, input, 1 / SIZE_PC, decode-stage redirect.
REQ-013 flagCallID_i / callPCID_i, input, 1 / SIZE_PC, decode-found call whose return address is pushed.
REQ-014 rasTosRestore_i, input, log2(RAS_DEPTH), RAS checkpoint restored on EX/ID redirect.
REQ-015 btbHit_i / prediction_i, input, FETCH_WIDTH each, per-slot BTB hit and direction prediction.
REQ-016 ctrlType_i, input, 2*FETCH_WIDTH, per-slot type: 00 return, 01 call, 10 jump, 11 conditional.
REQ-017 targetAddr_i, input, SIZE_PC*FETCH_WIDTH, per-slot BTB target.
REQ-018 icacheMiss_i / refillDone_i, input, 1 each, I-cache miss for the current PC / refill complete.
REQ-019 pc_o, output, SIZE_PC, current fetch PC.
REQ-020 fetchValid_o, output, 1, fetch bundle at pc_o is valid this cycle.
REQ-021 takenSlot_o / takenValid_o, output, log2(FETCH_WIDTH) / 1, first predicted-taken slot.
REQ-022 rasTos_o / rasTop_o / rasEmpty_o, output, log2(RAS_DEPTH) / SIZE_PC / 1, checkpoint pointer, top entry, empty flag.

Function
REQ-023 Slot k is taken iff btbHit_i[k] and (prediction_i[k] or ctrlType != 11); takenSlot_o is the lowest such k.
REQ-024 Next-PC priority: recoverFlag_i > exceptionFlag_i > flagRecoverEX_i > flagRecoverID_i > taken slot (type 00 -> rasTop_o, else target) > PC + FETCH_WIDTH*INST_BYTES, all modulo 2^SIZE_PC.
REQ-025 Any of the four redirects loads PC on the next edge regardless of stall_i or FSM state; otherwise PC advances only in RUN with ~stall_i and ~icacheMiss_i.
REQ-026 FSM states RUN, MISS_WAIT: RUN plus icacheMiss_i plus no redirect -> MISS_WAIT (PC held); MISS_WAIT plus refillDone_i -> RUN (same PC refetched); any redirect -> RUN.
REQ-027 fetchValid_o = (state==RUN) and ~icacheMiss_i, combinational.
REQ-028 RAS is circular: a push (taken call in slot k, PC advancing) writes PC+(k+1)*INST_BYTES at tos+1 and increments tos; a pop (taken return, PC advancing) decrements tos.
REQ-029 Overflow overwrites the oldest entry; count saturates at RAS_DEPTH; pop at count 0 still wraps tos, rasEmpty_o stays 1.
REQ-030 EX/ID redirect sets tos to rasTosRestore_i; ID redirect with flagCallID_i additionally pushes callPCID_i in the same edge; no speculative push/pop that cycle.
REQ-031 recoverFlag_i or exceptionFlag_i clears tos and count to 0.

Reset
REQ-032 On reset low, asynchronously: PC=RESET_PC, state RUN, tos 0, count 0, RAS entries 0; hence pc_o=RESET_PC, rasEmpty_o=1, rasTop_o=0, fetchValid_o follows icacheMiss_i.
REQ-033 Reset asserted mid-MISS_WAIT or mid-redirect abandons it; first post-reset edge behaves as from RUN.

Structure
REQ-034 Shared package fetch_pkg holds control-type constants (RETURN, CALL, JUMP, COND) and the FSM state type.
REQ-035 RAS is the sub-module ras_stack (push, pop, restore, clear ports); priority logic and FSM stay in fetch_pc_gen.

Verification
REQ-036 Reset, no hits, no stall, 3 edges -> pc_o 0x00, 0x20, 0x40, 0x60 (defaults).
REQ-037 Slot 2 call to 0x400 at PC 0x100 -> PC 0x400, rasTop_o 0x118; then slot 0 return -> PC 0x118, rasEmpty_o 1.
REQ-038 Simultaneous recoverFlag_i (0x800) and flagRecoverEX_i (0x900) -> PC 0x800, tos 0.
REQ-039 icacheMiss_i at PC 0x200 -> MISS_WAIT, fetchValid_o 0, PC held; refillDone_i -> RUN at 0x200; redirect to 0x300 during MISS_WAIT -> RUN at 0x300.
REQ-040 17 calls with RAS_DEPTH 16 -> count 16, oldest lost; 16 returns produce the 16 newest addresses in reverse order.
REQ-041 Stall held with taken call -> PC and tos unchanged; flagRecoverEX_i during stall still redirects.
